// File: rtl/ifetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
// Optional feature macro used by this block: IFETCH_PERF_EN.
package ifetch_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam logic [DEF_DATA_W-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifetch_state_t;

    // Prefetch queue entry at default widths: instruction word and its address
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ADDR_W-1:0] pc;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Synchronous FIFO with push, pop, flush and occupancy count.
// A pop in the same cycle as a flush still retires the head; a flush drops any push.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = ifetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  entry_t                       push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output entry_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           slot [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Circular pointer advance for non power-of-two depths
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Qualify requests against occupancy; full push is legal only alongside a pop
    assign do_pop  = pop && (count != '0);
    assign do_push = push && !flush && ((count != FULL_CNT) || do_pop);
    assign head    = slot[rd_ptr];

    // Storage, pointers and count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot[i] <= '0;
            end
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= push_entry;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= next_ptr(wr_ptr);
                end
                if (do_pop) begin
                    rd_ptr <= next_ptr(rd_ptr);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: drives the instruction bank read port, buffers fetched
// words with their PC in a prefetch queue, and hands them to decode over valid/ready.
// Supports redirect with flush and self-halts on HALT_WORD.
// Optional feature macro: IFETCH_PERF_EN adds fetch_count / flush_count outputs.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEF_ADDR_W,
    parameter int unsigned        DATA_W    = DEF_DATA_W,
    parameter int unsigned        DEPTH     = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(DEF_HALT_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              memread,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] readdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef IFETCH_PERF_EN
    output logic [15:0]       fetch_count,
    output logic [15:0]       flush_count,
`endif
    output logic              halted
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    ifetch_state_t     state;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  q_count;
    entry_t            q_head;
    entry_t            q_push_entry;
    logic              q_full;
    logic              pop;
    logic              fetch;

    // Fetch only in RUN, never under redirect, and only when a slot is or becomes free
    assign pop          = inst_valid && inst_ready;
    assign q_full       = (q_count == CNT_W'(DEPTH));
    assign fetch        = (state == RUN) && !redirect && (!q_full || pop);
    assign memread      = fetch;
    assign address      = pc;
    assign q_push_entry = '{data: readdata, pc: pc};

    assign inst_valid = (q_count != '0);
    assign inst_data  = q_head.data;
    assign inst_pc    = q_head.pc;

    ifetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch),
        .push_entry (q_push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (q_head),
        .count      (q_count)
    );

    // Fetch controller; halted mirrors the HALT state as a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            halted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fetch && (readdata == HALT_WORD)) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    if (redirect) begin
                        state  <= en ? RUN : IDLE;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // Program counter: redirect target wins, else advance on each fetch (wraps silently)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (fetch) begin
            pc <= pc + ADDR_W'(1);
        end
    end

`ifdef IFETCH_PERF_EN
    // Saturating counters: pushes, and redirects that discard at least one queued entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (fetch && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (redirect && (q_count > CNT_W'(pop)) && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a queue-based model.
module tb_ifetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        memread;
    logic [7:0]  address;
    logic [31:0] readdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;
`ifdef IFETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] flush_count;
`endif

    logic [31:0] mem [256];

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    typedef struct {
        logic [31:0] d;
        logic [7:0]  p;
    } ent_t;
    ent_t        mq[$];
    int          m_mode;   // 0 idle, 1 run, 2 halt
    logic [7:0]  m_pc;
    int          m_fc;
    int          m_flc;
    logic        e_pop;
    logic        e_fetch;
    logic [31:0] e_word;

    ifetch_unit #(
        .ADDR_W    (8),
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .RESET_PC  (8'd0),
        .HALT_WORD (HALTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .memread     (memread),
        .address     (address),
        .readdata    (readdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef IFETCH_PERF_EN
        .fetch_count (fetch_count),
        .flush_count (flush_count),
`endif
        .halted      (halted)
    );

    assign readdata = memread ? mem[address] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic e, input logic r);
        rst_n = 1'b0; en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'd0;
        cyc(2);
        rst_n = 1'b1; en = e; inst_ready = r;
    endtask

    task automatic head_is(input string name, input logic [31:0] d, input logic [7:0] p);
        chk({name, "_valid"}, 32'(inst_valid), 32'd1);
        chk({name, "_data"}, inst_data, d);
        chk({name, "_pc"}, 32'(inst_pc), 32'(p));
    endtask

    // Model compare and advance on the falling edge; inputs are stable here
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_mode = 0; m_pc = 8'd0; m_fc = 0; m_flc = 0;
            chk("rst_memread", 32'(memread), 32'd0);
            chk("rst_address", 32'(address), 32'd0);
            chk("rst_valid", 32'(inst_valid), 32'd0);
            chk("rst_data", inst_data, 32'd0);
            chk("rst_pc", 32'(inst_pc), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
        end else begin
            e_pop   = (mq.size() != 0) && inst_ready;
            e_fetch = (m_mode == 1) && !redirect && ((mq.size() < DEPTH) || e_pop);
            chk("memread", 32'(memread), 32'(e_fetch));
            chk("address", 32'(address), 32'(m_pc));
            chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("inst_data", inst_data, mq[0].d);
                chk("inst_pc", 32'(inst_pc), 32'(mq[0].p));
            end
            chk("halted", 32'(halted), 32'(m_mode == 2));
`ifdef IFETCH_PERF_EN
            chk("fetch_count", 32'(fetch_count), 32'(m_fc));
            chk("flush_count", 32'(flush_count), 32'(m_flc));
`endif
            if (e_pop) void'(mq.pop_front());
            if (redirect) begin
                if (mq.size() > 0 && m_flc < 65535) m_flc++;
                mq.delete();
                m_pc   = redirect_pc;
                m_mode = en ? 1 : 0;
            end else if (e_fetch) begin
                e_word = mem[m_pc];
                mq.push_back('{e_word, m_pc});
                if (m_fc < 65535) m_fc++;
                m_pc = m_pc + 8'd1;
                m_mode = (e_word == HALTW) ? 2 : (en ? 1 : 0);
            end else if (m_mode != 2) begin
                m_mode = en ? 1 : 0;
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i * 10);
        rst_n = 1'b0; en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'd0;

        // Reset values
        #2;
        chk("r0_valid", 32'(inst_valid), 32'd0);
        chk("r0_address", 32'(address), 32'd0);
        chk("r0_memread", 32'(memread), 32'd0);
        chk("r0_halted", 32'(halted), 32'd0);
        chk("r0_data", inst_data, 32'd0);

        // Streaming with ready held high
        cyc(2);
        rst_n = 1'b1; en = 1'b1; inst_ready = 1'b1;
        cyc(); #1;
        chk("s_memread_c1", 32'(memread), 32'd1);
        chk("s_valid_c1", 32'(inst_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            head_is("s_head", 32'(k * 10), 8'(k));
            chk("s_memread", 32'(memread), 32'd1);
        end

        // Backpressure: queue fills with 0,10 and fetching stops
        do_reset(1'b1, 1'b0);
        cyc(3); #1;
        head_is("bp_full", 32'd0, 8'd0);
        chk("bp_memread", 32'(memread), 32'd0);
        cyc(2); #1;
        chk("bp_memread_hold", 32'(memread), 32'd0);
        head_is("bp_hold", 32'd0, 8'd0);
        inst_ready = 1'b1; #1;
        chk("bp_release_memread", 32'(memread), 32'd1);
        chk("bp_release_addr", 32'(address), 32'd2);
        cyc(); #1; head_is("bp_r1", 32'd10, 8'd1);
        cyc(); #1; head_is("bp_r2", 32'd20, 8'd2);
        cyc(); #1; head_is("bp_r3", 32'd30, 8'd3);

        // Redirect while queue holds pcs 5,6
        do_reset(1'b1, 1'b0);
        redirect = 1'b1; redirect_pc = 8'd5;
        cyc(); redirect = 1'b0;
        cyc(2); #1;
        head_is("rd_pre", 32'd50, 8'd5);
        chk("rd_pre_memread", 32'(memread), 32'd0);
        redirect = 1'b1; redirect_pc = 8'd200;
        cyc(); redirect = 1'b0; inst_ready = 1'b1; #1;
        chk("rd_bubble_valid", 32'(inst_valid), 32'd0);
        chk("rd_fetch_memread", 32'(memread), 32'd1);
        chk("rd_fetch_addr", 32'(address), 32'd200);
        cyc(); #1;
        head_is("rd_post", 32'd2000, 8'd200);
`ifdef IFETCH_PERF_EN
        chk("rd_flush_count", 32'(flush_count), 32'd1);
`endif

        // Halt word at address 3
        do_reset(1'b1, 1'b1);
        mem[3] = HALTW;
        cyc();
        cyc(); #1; head_is("h0", 32'd0, 8'd0);
        cyc(); #1; head_is("h1", 32'd10, 8'd1);
        cyc(); #1; head_is("h2", 32'd20, 8'd2);
        cyc(); #1; head_is("h3", HALTW, 8'd3);
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_memread", 32'(memread), 32'd0);
        cyc(); #1;
        chk("h_drained", 32'(inst_valid), 32'd0);
        chk("h_halted2", 32'(halted), 32'd1);
        redirect = 1'b1; redirect_pc = 8'd0;
        cyc(); redirect = 1'b0; #1;
        chk("h_exit_halted", 32'(halted), 32'd0);
        chk("h_exit_memread", 32'(memread), 32'd1);
        chk("h_exit_addr", 32'(address), 32'd0);
        cyc(); #1; head_is("h_refetch", 32'd0, 8'd0);
        mem[3] = 32'd30;

        // PC wrap 254 -> 1
        redirect = 1'b1; redirect_pc = 8'd254;
        cyc(); redirect = 1'b0;
        cyc(); #1; head_is("w254", 32'd2540, 8'd254);
        cyc(); #1; head_is("w255", 32'd2550, 8'd255);
        cyc(); #1; head_is("w0", 32'd0, 8'd0);
        cyc(); #1; head_is("w1", 32'd10, 8'd1);

        // Asynchronous reset with a full queue
        inst_ready = 1'b0;
        cyc(3); #1;
        chk("ar_full_valid", 32'(inst_valid), 32'd1);
        chk("ar_full_memread", 32'(memread), 32'd0);
        rst_n = 1'b0; #1;
        chk("ar_valid", 32'(inst_valid), 32'd0);
        chk("ar_address", 32'(address), 32'd0);
        chk("ar_halted", 32'(halted), 32'd0);
        cyc();
        rst_n = 1'b1; en = 1'b1; inst_ready = 1'b1;
        cyc(2); #1;
        head_is("ar_restart", 32'd0, 8'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            inst_ready  = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom);
            if ($urandom_range(0, 49) == 0) mem[$urandom_range(0, 255)] = HALTW;
            if ($urandom_range(0, 49) == 0) mem[$urandom_range(0, 255)] = $urandom;
            rst_n = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rst_n = 1'b1; redirect = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit that reads the instruction memory bank. It drives the bank's `memread`/`address` request side, captures the returned word, and buffers it with its PC in a small prefetch queue. Instructions go to the decode stage over a valid/ready handshake. It supports PC redirect (branch/jump) with flush, and self-halts on a designated halt word.

## Interface
- `ADDR_W`, 8: instruction address width, word-indexed.
- `DATA_W`, 32: instruction width.
- `DEPTH`, 2: prefetch queue entries, ≥1.
- `RESET_PC`, 0: PC value after reset.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops fetching.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  fetch enable.
- `memread`  out  1  read strobe to memory bank.
- `address`  out  ADDR_W  word address to memory bank.
- `readdata`  in  DATA_W  memory word; combinational from `address` while `memread`=1.
- `inst_valid`  out  1  head of queue valid.
- `inst_ready`  in  1  decode accepts head.
- `inst_data`  out  DATA_W  head instruction.
- `inst_pc`  out  ADDR_W  head instruction address.
- `redirect`  in  1  load new PC and flush queue.
- `redirect_pc`  in  ADDR_W  target PC.
- `halted`  out  1  high while in HALT.

## Operation
- The FSM has three states: IDLE, RUN and HALT.
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0. PC and queue are retained.
  - RUN→HALT when the word pushed equals `HALT_WORD`.
  - HALT is left only by `redirect`. The next state is RUN if `en`=1, otherwise IDLE.
- A fetch cycle occurs when all of the following hold:
  - state is RUN;
  - `redirect`=0;
  - queue count < DEPTH, or a pop occurs in the same cycle.
- In a fetch cycle, `memread`=1 and `address`=pc.
- At the clock edge ending a fetch cycle:
  - {`readdata`, pc} is pushed;
  - pc ← pc+1 modulo 2^ADDR_W. Wrap 255→0 is legal and silent.
- Outside fetch cycles, `memread`=0 and `address`=pc. The unit never uses `readdata` when `memread`=0.
- Pop: `inst_valid`=1 and `inst_ready`=1 at an edge. `inst_valid` = (count≠0), driven from registers only.
- Push and pop together when full is allowed; count is unchanged.
- Redirect has highest priority. At the edge:
  - any pop in that cycle still completes;
  - the queue is cleared;
  - pc ← `redirect_pc`;
  - no push occurs.
- A halt word is enqueued and delivered normally. The queue drains while in HALT.
- `en`=0 does not flush. Already-queued words still drain.

## Timing
- Reset values:
  - `memread`=0, `address`=RESET_PC;
  - `inst_valid`=0, `inst_data`=0, `inst_pc`=0;
  - `halted`=0, state=IDLE, count=0.
- Reset assertion mid-operation clears all of the above asynchronously.
- After reset with `en`=1:
  - edge 1 enters RUN;
  - first fetch cycle is cycle 1;
  - `inst_valid` rises after edge 2.
- Latency from fetch cycle to `inst_valid`: 1 cycle.
- Throughput: 1 instruction per cycle with `inst_ready` held high.
- Queue full with `inst_ready`=0: `memread` held 0 until a pop cycle.
- After a redirect edge: `inst_valid`=0 for exactly one cycle. The first fetch at `redirect_pc` occurs the cycle after the redirect.
- `halted` rises the cycle after the halt word's fetch edge.

## Configuration
- `IFETCH_PERF_EN` defined: adds two outputs.
  - `fetch_count` (16 bits): increments per push.
  - `flush_count` (16 bits): increments per redirect that discards ≥1 queued entry.
  - Both saturate at 16'hFFFF and reset to 0.
- `IFETCH_PERF_EN` undefined: both ports and their counters are absent. Functional behaviour is identical.

## Structure
- Shared package `ifetch_pkg`:
  - state enum `ifetch_state_t` (IDLE, RUN, HALT);
  - default `ADDR_W`/`DATA_W`/`HALT_WORD` constants;
  - queue entry struct {data, pc}.
- Sub-module `ifetch_queue`: parameterized synchronous FIFO with push/pop/flush and count.
- FSM, PC and optional counters live in `ifetch_unit`.

## Test plan
The bench memory model is initialised with mem[i]=i*10.

- Reset, `en`=1, `inst_ready`=1 → `inst_data` 0,10,20,30 with `inst_pc` 0,1,2,3 on consecutive cycles; `memread` continuously 1.
- `inst_ready`=0 for 5 cycles after the first fetch → after 2 pushes, `memread`=0 and the queue holds 0,10. On release, the stream resumes at 20 with no gap or duplicate.
- Redirect to pc 200 while the queue holds pcs 5,6 → pcs 5,6 discarded; next delivered is 2000 mod 2^32 at pc 200; `flush_count`=1 with `IFETCH_PERF_EN`.
- mem[3]=32'hFFFF_FFFF → words 0,10,20,FFFF_FFFF delivered, then `halted`=1, `memread`=0. Redirect to 0 clears `halted` and refetches 0.
- PC 254 via redirect, free-run → pcs 254,255,0,1 delivered in order.
- `rst_n` pulsed low with the queue full → `inst_valid`=0 immediately and `address`=RESET_PC. After release, fetch restarts from RESET_PC.
